// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB master and the slaves that sit on the bus
// (apb_slave1 and friends).
//   - apb_state_e    : transfer FSM encoding (IDLE, SETUP, ACCESS)
//   - ADDR_WIDTH_DEF : default bus address width
//   - DATA_WIDTH_DEF : default bus data width
// -----------------------------------------------------------------------------
package apb_pkg;

   localparam int ADDR_WIDTH_DEF = 32;
   localparam int DATA_WIDTH_DEF = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

endpackage : apb_pkg

// File: rtl/apb_addr_decode.sv
// -----------------------------------------------------------------------------
// apb_addr_decode
// Purely combinational address decoder. Each slave owns SLAVE_SPAN consecutive
// addresses. The slave index is addr / SLAVE_SPAN and the address presented
// on the bus is addr modulo SLAVE_SPAN.
// Ports:
//   addr_i          in   ADDR_WIDTH  command address
//   psel_o          out  NUM_SLAVES  one-hot select (all zero when out of range)
//   offset_o        out  ADDR_WIDTH  address within the selected slave
//   out_of_range_o  out  1           index >= NUM_SLAVES
// -----------------------------------------------------------------------------
module apb_addr_decode
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int NUM_SLAVES = 2,
   parameter int SLAVE_SPAN = 128
) (
   input  logic [ADDR_WIDTH-1:0] addr_i,
   output logic [NUM_SLAVES-1:0] psel_o,
   output logic [ADDR_WIDTH-1:0] offset_o,
   output logic                  out_of_range_o
);

   localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(SLAVE_SPAN);

   logic [ADDR_WIDTH-1:0] index;

   // NOTE: every output of a combinational block is given a value before any
   // conditional code; a path that leaves one unassigned infers a latch.
   always_comb begin
      index          = addr_i / SPAN;
      offset_o       = addr_i % SPAN;
      out_of_range_o = (index >= ADDR_WIDTH'(NUM_SLAVES));
      psel_o         = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         psel_o[i] = (index == ADDR_WIDTH'(i));
      end
   end

endmodule : apb_addr_decode

// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
// Single-outstanding APB master. A command handshaken in IDLE runs one
// SETUP cycle and then ACCESS until the selected slave raises pready_i.
// Completion is reported with a one-cycle rsp_valid_o pulse the cycle after
// the completing ACCESS cycle; a new command may be accepted in that cycle.
// Addresses that decode beyond NUM_SLAVES never touch the bus and return an
// error response the following cycle.
//
// Optional feature (macro APB_MASTER_TIMEOUT_EN): ACCESS is aborted with an
// error after TIMEOUT_CYCLES consecutive not-ready cycles. Without the macro
// ACCESS waits indefinitely.
//
// Ports:
//   pclk_i       in   1           clock, rising edge
//   prst_i       in   1           synchronous active-high reset
//   cmd_valid_i  in   1           command request
//   cmd_ready_o  out  1           command accepted this cycle (IDLE only)
//   cmd_write_i  in   1           1 = write, 0 = read
//   cmd_addr_i   in   ADDR_WIDTH  target address
//   cmd_wdata_i  in   DATA_WIDTH  write data
//   rsp_valid_o  out  1           one-cycle completion pulse
//   rsp_rdata_o  out  DATA_WIDTH  read data (0 for writes and errors)
//   rsp_err_o    out  1           decode error or timeout
//   paddr_o      out  ADDR_WIDTH  APB address (offset within the slave)
//   psel_o       out  NUM_SLAVES  one-hot APB select
//   penable_o    out  1           APB enable
//   pwrite_o     out  1           APB direction
//   pwdata_o     out  DATA_WIDTH  APB write data
//   pready_i     in   1           selected slave ready
//   prdata_i     in   DATA_WIDTH  selected slave read data
// -----------------------------------------------------------------------------
module apb_master
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int NUM_SLAVES     = 2,
   parameter int SLAVE_SPAN     = 128,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  pclk_i,
   input  logic                  prst_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_write_i,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
   output logic                  rsp_valid_o,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic [ADDR_WIDTH-1:0] paddr_o,
   output logic [NUM_SLAVES-1:0] psel_o,
   output logic                  penable_o,
   output logic                  pwrite_o,
   output logic [DATA_WIDTH-1:0] pwdata_o,
   input  logic                  pready_i,
   input  logic [DATA_WIDTH-1:0] prdata_i
);

   // Elaboration-time guard against meaningless configurations.
   if (NUM_SLAVES < 1 || SLAVE_SPAN < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("apb_master: NUM_SLAVES, SLAVE_SPAN and TIMEOUT_CYCLES must be >= 1");
   end

   // ---------------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------------
   logic [NUM_SLAVES-1:0] dec_psel;
   logic [ADDR_WIDTH-1:0] dec_offset;
   logic                  dec_oor;

   apb_addr_decode #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_SLAVES (NUM_SLAVES),
      .SLAVE_SPAN (SLAVE_SPAN)
   ) u_addr_decode (
      .addr_i         (cmd_addr_i),
      .psel_o         (dec_psel),
      .offset_o       (dec_offset),
      .out_of_range_o (dec_oor)
   );

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   apb_state_e            state_q,     state_d;
   logic [NUM_SLAVES-1:0] sel_q,       sel_d;
   logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
   logic                  pwrite_q,    pwrite_d;
   logic [DATA_WIDTH-1:0] pwdata_q,    pwdata_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_err_q,   rsp_err_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

   // tmo_hit: this ACCESS cycle is the last not-ready cycle allowed.
   logic tmo_hit;

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      if (state_q == SETUP) begin
         tmo_cnt_d = '0;
      end else if (state_q == ACCESS && !pready_i) begin
         tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge pclk_i) begin
      if (prst_i) begin
         tmo_cnt_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end

   // The counter reads k-1 during the k-th ACCESS cycle, so the abort is taken
   // at the end of the TIMEOUT_CYCLES-th not-ready cycle.
   assign tmo_hit = (state_q == ACCESS) && !pready_i &&
                    (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Next-state and response logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      paddr_d     = paddr_q;
      pwrite_d    = pwrite_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;

      unique case (state_q)
         IDLE: begin
            if (cmd_valid_i) begin
               if (dec_oor) begin
                  // Out-of-range: answer directly, leave the bus untouched so
                  // the APB outputs keep their last values.
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
               end else begin
                  sel_d    = dec_psel;
                  paddr_d  = dec_offset;
                  pwrite_d = cmd_write_i;
                  pwdata_d = cmd_wdata_i;
                  state_d  = SETUP;
               end
            end
         end

         SETUP: begin
            // pready_i is not looked at here; only ACCESS can complete.
            state_d = ACCESS;
         end

         ACCESS: begin
            if (pready_i) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = pwrite_q ? '0 : prdata_i;
            end else if (tmo_hit) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, regardless of statement order.
   always_ff @(posedge pclk_i) begin
      if (prst_i) begin
         state_q     <= IDLE;
         sel_q       <= '0;
         paddr_q     <= '0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         paddr_q     <= paddr_d;
         pwrite_q    <= pwrite_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   // The latched select is only shown on the bus during a transfer, so psel_o
   // and penable_o drop in IDLE while address/data keep their last values.
   assign psel_o      = (state_q == SETUP || state_q == ACCESS) ? sel_q : '0;
   assign penable_o   = (state_q == ACCESS);
   assign cmd_ready_o = (state_q == IDLE);
   assign paddr_o     = paddr_q;
   assign pwrite_o    = pwrite_q;
   assign pwdata_o    = pwdata_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_err_o   = rsp_err_q;
   assign rsp_rdata_o = rsp_rdata_q;

endmodule : apb_master

// File: tb/tb_apb_master.sv
// -----------------------------------------------------------------------------
// tb_apb_master
// Directed bench for apb_master with two model slaves (16 words each) behind
// a pready generator that inserts wait_states not-ready ACCESS cycles.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_apb_master;
   import apb_pkg::*;

   localparam int AW = ADDR_WIDTH_DEF;
   localparam int DW = DATA_WIDTH_DEF;
   localparam int NS = 2;

   logic          pclk_i = 1'b0;
   logic          prst_i;
   logic          cmd_valid_i;
   logic          cmd_ready_o;
   logic          cmd_write_i;
   logic [AW-1:0] cmd_addr_i;
   logic [DW-1:0] cmd_wdata_i;
   logic          rsp_valid_o;
   logic [DW-1:0] rsp_rdata_o;
   logic          rsp_err_o;
   logic [AW-1:0] paddr_o;
   logic [NS-1:0] psel_o;
   logic          penable_o;
   logic          pwrite_o;
   logic [DW-1:0] pwdata_o;
   logic          pready_i;
   logic [DW-1:0] prdata_i;

   always #5 pclk_i = ~pclk_i;

   apb_master #(
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .NUM_SLAVES     (NS),
      .SLAVE_SPAN     (128),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .pclk_i      (pclk_i),
      .prst_i      (prst_i),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_write_i (cmd_write_i),
      .cmd_addr_i  (cmd_addr_i),
      .cmd_wdata_i (cmd_wdata_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_err_o   (rsp_err_o),
      .paddr_o     (paddr_o),
      .psel_o      (psel_o),
      .penable_o   (penable_o),
      .pwrite_o    (pwrite_o),
      .pwdata_o    (pwdata_o),
      .pready_i    (pready_i),
      .prdata_i    (prdata_i)
   );

   int n_pass  = 0;
   int n_total = 0;

   // ---------------------------------------------------------------------------
   // Model slaves: slave 0 is apb_slave1's address window 0..127, slave 1 is
   // 128..255. pready rises after wait_states not-ready ACCESS cycles; since
   // acc_cnt is 0 outside ACCESS, pready is high in IDLE/SETUP when
   // wait_states is 0, which the master must ignore.
   // ---------------------------------------------------------------------------
   int            wait_states = 0;
   int            acc_cnt     = 0;
   logic [DW-1:0] mem [2][16];

   assign pready_i = (acc_cnt >= wait_states);
   assign prdata_i = mem[psel_o[1]][paddr_o[3:0]];

   always @(posedge pclk_i) begin
      if (penable_o && !pready_i) acc_cnt <= acc_cnt + 1;
      else                        acc_cnt <= 0;
      if (prst_i) begin
         mem[1][2] <= 32'hCAFE_0130;
      end else if (psel_o != '0 && penable_o && pready_i && pwrite_o) begin
         mem[psel_o[1]][paddr_o[3:0]] <= pwdata_o;
      end
   end

   // Called on a falling edge in IDLE; returns on the next falling edge.
   task automatic cmd_start(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      cmd_valid_i = 1'b1;
      cmd_write_i = w;
      cmd_addr_i  = a;
      cmd_wdata_i = d;
      @(negedge pclk_i);
      cmd_valid_i = 1'b0;
   endtask

   task automatic test_reset();
      prst_i = 1'b1;
      repeat (3) @(negedge pclk_i);
      prst_i = 1'b0;
      @(negedge pclk_i);
      n_total++; if (cmd_ready_o !== 1'b1) $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready_o); else n_pass++;
      n_total++; if (rsp_valid_o !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid_o); else n_pass++;
      n_total++; if (rsp_err_o !== 1'b0) $display("FAIL rst_rsp_err: got %b want 0", rsp_err_o); else n_pass++;
      n_total++; if (psel_o !== 2'b00) $display("FAIL rst_psel: got %b want 00", psel_o); else n_pass++;
      n_total++; if (penable_o !== 1'b0) $display("FAIL rst_penable: got %b want 0", penable_o); else n_pass++;
      n_total++; if (pwrite_o !== 1'b0) $display("FAIL rst_pwrite: got %b want 0", pwrite_o); else n_pass++;
      n_total++; if (paddr_o !== 32'd0) $display("FAIL rst_paddr: got %h want 0", paddr_o); else n_pass++;
      n_total++; if (pwdata_o !== 32'd0) $display("FAIL rst_pwdata: got %h want 0", pwdata_o); else n_pass++;
      n_total++; if (rsp_rdata_o !== 32'd0) $display("FAIL rst_rdata: got %h want 0", rsp_rdata_o); else n_pass++;
   endtask

   task automatic test_write();
      cmd_start(1'b1, 32'd5, 32'hA5);
      // SETUP
      n_total++; if (psel_o !== 2'b01) $display("FAIL wr_setup_psel: got %b want 01", psel_o); else n_pass++;
      n_total++; if (penable_o !== 1'b0) $display("FAIL wr_setup_penable: got %b want 0", penable_o); else n_pass++;
      n_total++; if (paddr_o !== 32'd5) $display("FAIL wr_setup_paddr: got %h want 5", paddr_o); else n_pass++;
      n_total++; if (pwrite_o !== 1'b1) $display("FAIL wr_setup_pwrite: got %b want 1", pwrite_o); else n_pass++;
      n_total++; if (pwdata_o !== 32'hA5) $display("FAIL wr_setup_pwdata: got %h want a5", pwdata_o); else n_pass++;
      n_total++; if (cmd_ready_o !== 1'b0) $display("FAIL wr_setup_ready: got %b want 0", cmd_ready_o); else n_pass++;
      @(negedge pclk_i);
      // ACCESS, pready already high
      n_total++; if (psel_o !== 2'b01 || penable_o !== 1'b1) $display("FAIL wr_access: got psel=%b pen=%b want 01/1", psel_o, penable_o); else n_pass++;
      n_total++; if (rsp_valid_o !== 1'b0) $display("FAIL wr_access_rsp: got %b want 0", rsp_valid_o); else n_pass++;
      @(negedge pclk_i);
      // T+3: response, bus idle, address held
      n_total++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0) $display("FAIL wr_rsp: got v=%b e=%b want 1/0", rsp_valid_o, rsp_err_o); else n_pass++;
      n_total++; if (rsp_rdata_o !== 32'd0) $display("FAIL wr_rsp_rdata: got %h want 0", rsp_rdata_o); else n_pass++;
      n_total++; if (psel_o !== 2'b00 || penable_o !== 1'b0) $display("FAIL wr_idle_bus: got psel=%b pen=%b want 00/0", psel_o, penable_o); else n_pass++;
      n_total++; if (paddr_o !== 32'd5 || pwdata_o !== 32'hA5) $display("FAIL wr_idle_hold: got %h/%h want 5/a5", paddr_o, pwdata_o); else n_pass++;
      n_total++; if (mem[0][5] !== 32'hA5) $display("FAIL wr_slave_mem: got %h want a5", mem[0][5]); else n_pass++;
      @(negedge pclk_i);
      n_total++; if (rsp_valid_o !== 1'b0) $display("FAIL wr_rsp_pulse: got %b want 0", rsp_valid_o); else n_pass++;
   endtask

   task automatic test_read();
      cmd_start(1'b0, 32'd5, 32'h0);
      n_total++; if (psel_o !== 2'b01 || penable_o !== 1'b0 || pwrite_o !== 1'b0) $display("FAIL rd_setup: got psel=%b pen=%b wr=%b want 01/0/0", psel_o, penable_o, pwrite_o); else n_pass++;
      @(negedge pclk_i);
      n_total++; if (penable_o !== 1'b1) $display("FAIL rd_penable: got %b want 1", penable_o); else n_pass++;
      @(negedge pclk_i);
      n_total++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0) $display("FAIL rd_rsp: got v=%b e=%b want 1/0", rsp_valid_o, rsp_err_o); else n_pass++;
      n_total++; if (rsp_rdata_o !== 32'hA5) $display("FAIL rd_rdata: got %h want a5", rsp_rdata_o); else n_pass++;
      @(negedge pclk_i);
   endtask

   task automatic test_wait_states();
      int  acc;
      bit  got;
      acc = 0;
      got = 1'b0;
      wait_states = 3;
      cmd_start(1'b0, 32'd130, 32'h0);
      n_total++; if (psel_o !== 2'b10 || penable_o !== 1'b0) $display("FAIL ws_setup: got psel=%b pen=%b want 10/0", psel_o, penable_o); else n_pass++;
      n_total++; if (paddr_o !== 32'd2) $display("FAIL ws_paddr: got %h want 2", paddr_o); else n_pass++;
      for (int i = 0; i < 20; i++) begin
         @(negedge pclk_i);
         if (penable_o) acc++;
         if (rsp_valid_o) begin
            got = 1'b1;
            break;
         end
      end
      n_total++; if (!got) $display("FAIL ws_rsp_timeout: got no rsp_valid want rsp within 20 cycles"); else n_pass++;
      n_total++; if (acc != 4) $display("FAIL ws_access_cycles: got %0d want 4", acc); else n_pass++;
      n_total++; if (rsp_rdata_o !== 32'hCAFE_0130 || rsp_err_o !== 1'b0) $display("FAIL ws_rdata: got %h e=%b want cafe0130/0", rsp_rdata_o, rsp_err_o); else n_pass++;
      @(negedge pclk_i);
      n_total++; if (rsp_valid_o !== 1'b0) $display("FAIL ws_rsp_pulse: got %b want 0", rsp_valid_o); else n_pass++;
      wait_states = 0;
   endtask

   // Decode error, then two back-to-back commands issued in response cycles.
   task automatic test_back_to_back();
      cmd_start(1'b0, 32'd300, 32'h0);
      n_total++; if (psel_o !== 2'b00 || penable_o !== 1'b0) $display("FAIL de_bus: got psel=%b pen=%b want 00/0", psel_o, penable_o); else n_pass++;
      n_total++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1) $display("FAIL de_rsp: got v=%b e=%b want 1/1", rsp_valid_o, rsp_err_o); else n_pass++;
      n_total++; if (rsp_rdata_o !== 32'd0) $display("FAIL de_rdata: got %h want 0", rsp_rdata_o); else n_pass++;
      n_total++; if (cmd_ready_o !== 1'b1) $display("FAIL de_ready: got %b want 1", cmd_ready_o); else n_pass++;
      cmd_start(1'b1, 32'd7, 32'h1234);
      n_total++; if (psel_o !== 2'b01 || paddr_o !== 32'd7) $display("FAIL b2b_setup: got psel=%b addr=%h want 01/7", psel_o, paddr_o); else n_pass++;
      repeat (2) @(negedge pclk_i);
      n_total++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0) $display("FAIL b2b_wr_rsp: got v=%b e=%b want 1/0", rsp_valid_o, rsp_err_o); else n_pass++;
      cmd_start(1'b0, 32'd7, 32'h0);
      n_total++; if (psel_o !== 2'b01 || penable_o !== 1'b0) $display("FAIL b2b_rd_setup: got psel=%b pen=%b want 01/0", psel_o, penable_o); else n_pass++;
      repeat (2) @(negedge pclk_i);
      n_total++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h1234) $display("FAIL b2b_rd_rsp: got v=%b d=%h want 1/1234", rsp_valid_o, rsp_rdata_o); else n_pass++;
      @(negedge pclk_i);
   endtask

   task automatic test_timeout();
      wait_states = 1000;
      cmd_start(1'b0, 32'd6, 32'h0);
`ifdef APB_MASTER_TIMEOUT_EN
      begin
         int acc;
         bit got;
         acc = 0;
         got = 1'b0;
         for (int i = 0; i < 40; i++) begin
            @(negedge pclk_i);
            if (penable_o) acc++;
            if (rsp_valid_o) begin
               got = 1'b1;
               break;
            end
         end
         n_total++; if (!got) $display("FAIL to_rsp_timeout: got no rsp_valid want rsp within 40 cycles"); else n_pass++;
         n_total++; if (acc != 16) $display("FAIL to_access_cycles: got %0d want 16", acc); else n_pass++;
         n_total++; if (rsp_err_o !== 1'b1 || rsp_rdata_o !== 32'd0) $display("FAIL to_rsp: got e=%b d=%h want 1/0", rsp_err_o, rsp_rdata_o); else n_pass++;
         n_total++; if (cmd_ready_o !== 1'b1 || psel_o !== 2'b00) $display("FAIL to_idle: got rdy=%b psel=%b want 1/00", cmd_ready_o, psel_o); else n_pass++;
      end
`else
      begin
         bit seen;
         seen = 1'b0;
         repeat (100) begin
            @(negedge pclk_i);
            if (rsp_valid_o) seen = 1'b1;
         end
         n_total++; if (seen) $display("FAIL hang_rsp: got rsp_valid want none"); else n_pass++;
         n_total++; if (penable_o !== 1'b1 || psel_o !== 2'b01) $display("FAIL hang_access: got pen=%b psel=%b want 1/01", penable_o, psel_o); else n_pass++;
         n_total++; if (cmd_ready_o !== 1'b0) $display("FAIL hang_ready: got %b want 0", cmd_ready_o); else n_pass++;
      end
`endif
   endtask

   task automatic test_reset_abort();
      bit seen;
      seen = 1'b0;
      prst_i = 1'b1;
      @(negedge pclk_i);
      prst_i = 1'b0;
      wait_states = 1000;
      cmd_start(1'b1, 32'd3, 32'h77);
      repeat (2) @(negedge pclk_i);
      n_total++; if (penable_o !== 1'b1) $display("FAIL ra_in_access: got %b want 1", penable_o); else n_pass++;
      prst_i = 1'b1;
      @(negedge pclk_i);
      n_total++; if (psel_o !== 2'b00 || penable_o !== 1'b0) $display("FAIL ra_bus_drop: got psel=%b pen=%b want 00/0", psel_o, penable_o); else n_pass++;
      n_total++; if (pwrite_o !== 1'b0 || paddr_o !== 32'd0) $display("FAIL ra_cleared: got wr=%b addr=%h want 0/0", pwrite_o, paddr_o); else n_pass++;
      prst_i = 1'b0;
      wait_states = 0;
      repeat (3) begin
         if (rsp_valid_o) seen = 1'b1;
         @(negedge pclk_i);
      end
      n_total++; if (seen) $display("FAIL ra_no_rsp: got rsp_valid want none"); else n_pass++;
      n_total++; if (cmd_ready_o !== 1'b1) $display("FAIL ra_ready: got %b want 1", cmd_ready_o); else n_pass++;
      cmd_start(1'b0, 32'd5, 32'h0);
      repeat (2) @(negedge pclk_i);
      n_total++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rsp_rdata_o !== 32'hA5) $display("FAIL ra_next_cmd: got v=%b e=%b d=%h want 1/0/a5", rsp_valid_o, rsp_err_o, rsp_rdata_o); else n_pass++;
      @(negedge pclk_i);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      prst_i      = 1'b1;
      cmd_valid_i = 1'b0;
      cmd_write_i = 1'b0;
      cmd_addr_i  = '0;
      cmd_wdata_i = '0;
      test_reset();
      test_write();
      test_read();
      test_wait_states();
      test_back_to_back();
      test_timeout();
      test_reset_abort();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_apb_master
